ldm_stm_seq: RTL

Block-transfer sequencer for LDM/STM. It latches a 16-bit register list, base address and P/U/L/W mode bits when the instruction reaches EX. It then drives the memory-control interface one word per listed register, stalling the upstream pipeline while busy, and finally issues the base-register writeback. It sits beside the EX stage and owns the memctrl port for the duration of a block transfer.

---
 rtl/ldm_stm_seq_if.sv | 20 ++
 rtl/ldm_stm_seq.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ldm_stm_seq_if.sv
// Memory-control beat bus between the LDM/STM sequencer (master) and the
// data-memory controller (slave).
interface ldm_stm_seq_if;
  logic        o_memctrl_vld;
  logic        o_memctrl_wr;
  logic [1:0]  o_memctrl_size;
  logic [31:0] o_memctrl_addr;
  logic [3:0]  o_rd_code;
  logic        i_mem_ready;

  modport master (
    output o_memctrl_vld, o_memctrl_wr, o_memctrl_size, o_memctrl_addr, o_rd_code,
    input  i_mem_ready
  );

  modport slave (
    input  o_memctrl_vld, o_memctrl_wr, o_memctrl_size, o_memctrl_addr, o_rd_code,
    output i_mem_ready
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: one memory beat per listed register,
// lowest register at lowest address, then a single-cycle base writeback.
module ldm_stm_seq (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [15:0]        i_reg_list,
  input  logic [31:0]        i_base,
  input  logic [3:0]         i_base_code,
  input  logic               i_load,
  input  logic               i_pre,
  input  logic               i_up,
  input  logic               i_wback,
  ldm_stm_seq_if.master      mem,
  output logic               o_busy,
  output logic               o_wb_en,
  output logic [3:0]         o_wb_code,
  output logic [31:0]        o_wb_reg,
  output logic               o_done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_XFER   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 16; i++) s = s + {4'd0, v[i]};
    return s;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [15:0] list_q, list_d;
  logic [31:0] addr_q, addr_d;
  logic        load_q;
  logic [3:0]  base_code_q;
  logic [31:0] wb_reg_q;
  logic        wb_en_q;

  logic        accept;
  logic [4:0]  n_regs;
  logic [6:0]  four_n;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic [31:0] final_base;
  logic [3:0]  low_idx;
  logic        xfer, fin;

  assign accept = (state_q == S_IDLE) && i_start;
  assign n_regs = popcount16(i_reg_list);
  assign four_n = {n_regs, 2'b00};
  assign span   = {25'd0, four_n};

  // Beats always ascend, so the decrementing modes start at the bottom of the block.
  always_comb begin
    case ({i_pre, i_up})
      2'b01:   start_addr = i_base;
      2'b11:   start_addr = i_base + 32'd4;
      2'b00:   start_addr = i_base - span + 32'd4;
      default: start_addr = i_base - span;
    endcase
  end

  assign final_base = i_up ? (i_base + span) : (i_base - span);

  always_comb begin
    low_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (list_q[i]) low_idx = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          list_d  = i_reg_list;
          addr_d  = start_addr;
          state_d = (i_reg_list != 16'd0) ? S_XFER : S_FINISH;
        end
      end
      S_XFER: begin
        if (mem.i_mem_ready) begin
          list_d = list_q & (list_q - 16'd1);
          addr_d = addr_q + 32'd4;
          if (list_d == 16'd0) state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      list_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
    end
  end

  // A load into the base register overrides the writeback.
  always_ff @(posedge i_clk) begin
    addr_q <= addr_d;
    if (accept) begin
      load_q      <= i_load;
      base_code_q <= i_base_code;
      wb_reg_q    <= final_base;
      wb_en_q     <= i_wback & ~(i_load & i_reg_list[i_base_code]);
    end
  end

  assign xfer = (state_q == S_XFER);
  assign fin  = (state_q == S_FINISH);

  assign o_busy             = (state_q != S_IDLE);
  assign mem.o_memctrl_vld  = xfer;
  assign mem.o_memctrl_wr   = xfer & ~load_q;
  assign mem.o_memctrl_size = xfer ? 2'b10 : 2'b00;
  assign mem.o_memctrl_addr = xfer ? addr_q : 32'd0;
  assign mem.o_rd_code      = xfer ? low_idx : 4'd0;
  assign o_done             = fin;
  assign o_wb_en            = fin & wb_en_q;
  assign o_wb_code          = fin ? base_code_q : 4'd0;
  assign o_wb_reg           = fin ? wb_reg_q : 32'd0;

endmodule
